// File: rtl/psram_xfer_seq_if.sv
// Host-side control/data bundle for psram_xfer_seq.
// master = transfer requester, slave = the sequencer.
interface psram_xfer_seq_if;
    logic        start;
    logic [7:0]  cmd;
    logic [1:0]  cmd_width;
    logic        cmd_only;
    logic [23:0] addr;
    logic [1:0]  addr_width;
    logic [3:0]  wait_cyc;
    logic [1:0]  data_width;
    logic        data_dir;
    logic [14:0] data_len;
    logic [3:0]  sck_div;
    logic        single_line_io_mode;
    logic [7:0]  tx_data;
    logic        tx_pop;
    logic [7:0]  rx_data;
    logic        rx_push;
    logic        busy;
    logic        done;

    modport master (
        output start, cmd, cmd_width, cmd_only, addr, addr_width, wait_cyc,
               data_width, data_dir, data_len, sck_div, single_line_io_mode,
               tx_data,
        input  tx_pop, rx_data, rx_push, busy, done
    );

    modport slave (
        input  start, cmd, cmd_width, cmd_only, addr, addr_width, wait_cyc,
               data_width, data_dir, data_len, sck_div, single_line_io_mode,
               tx_data,
        output tx_pop, rx_data, rx_push, busy, done
    );
endinterface

// File: rtl/psram_xfer_seq.sv
// PSRAM command/address/wait/data transfer sequencer, SPI mode 0, x1/x2/x4 lanes.
// Define PSRAM_RX_LATE_SAMPLE_EN to sample read data on SCK falling edges.
//
// state | meaning
// IDLE  | waiting for start, ce_n high
// CMD   | shifting the 8-bit opcode
// ADDR  | shifting the 24-bit address
// WAIT  | dummy SCK cycles, lanes released
// DATA  | write or read bytes
// END   | ce_n high for sck_div+1 clk, then done
module psram_xfer_seq (
    input  logic              clk,
    input  logic              rst_n,
    psram_xfer_seq_if.slave   host,
    output logic              psram_sck,
    output logic              psram_ce_n,
    output logic [3:0]        psram_io_out,
    output logic [3:0]        psram_io_oe,
    input  logic [3:0]        psram_io_in
);

`ifdef PSRAM_RX_LATE_SAMPLE_EN
    localparam logic LATE_SAMPLE = 1'b1;
`else
    localparam logic LATE_SAMPLE = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, CMD, ADDR, WAIT, DATA, END} state_t;

    state_t      state, adv_state;
    logic        c_cmd_only, c_data_dir, c_single;
    logic [1:0]  c_cmd_width, c_addr_width, c_data_width, cur_w;
    logic [23:0] c_addr;
    logic [3:0]  c_wait_cyc, c_sck_div, div_cnt;
    logic [14:0] c_data_len, byte_rem;
    logic [4:0]  sck_cnt;
    logic [31:0] sh, sh_next;
    logic [7:0]  rx_sh, rx_next, rx_data;
    logic        tx_pop, rx_push, busy, done;
    logic        tick, sample_now, shifting;

    function automatic logic [3:0] lane_mask(input logic [1:0] w);
        case (w)
            2'd0:    return 4'b0001;
            2'd1:    return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [3:0] lane_drive(input logic [31:0] s, input logic [1:0] w);
        case (w)
            2'd0:    return {3'b000, s[31]};
            2'd1:    return {2'b00, s[31:30]};
            default: return s[31:28];
        endcase
    endfunction

    function automatic logic [31:0] shift_out(input logic [31:0] s, input logic [1:0] w);
        case (w)
            2'd0:    return {s[30:0], 1'b0};
            2'd1:    return {s[29:0], 2'b00};
            default: return {s[27:0], 4'b0000};
        endcase
    endfunction

    // Index of the last SCK in a phase: 8-bit fields (cmd/byte) or the 24-bit address.
    function automatic logic [4:0] last_sck(input logic [1:0] w, input logic is_addr);
        case (w)
            2'd0:    return is_addr ? 5'd23 : 5'd7;
            2'd1:    return is_addr ? 5'd11 : 5'd3;
            default: return is_addr ? 5'd5  : 5'd1;
        endcase
    endfunction

    assign host.tx_pop  = tx_pop;
    assign host.rx_data = rx_data;
    assign host.rx_push = rx_push;
    assign host.busy    = busy;
    assign host.done    = done;

    assign tick       = (div_cnt == 4'd0);
    assign sample_now = (state == DATA) && c_data_dir && tick &&
                        (LATE_SAMPLE ? psram_sck : !psram_sck);
    assign shifting   = (state == CMD) || (state == ADDR) ||
                        ((state == DATA) && !c_data_dir);
    assign sh_next    = shift_out(sh, cur_w);

    always_comb begin
        cur_w = c_data_width;
        if (state == CMD)
            cur_w = c_cmd_width;
        else if (state == ADDR)
            cur_w = c_addr_width;
    end

    always_comb begin
        rx_next = rx_sh;
        case (c_data_width)
            2'd0:    rx_next = {rx_sh[6:0], c_single ? psram_io_in[0] : psram_io_in[1]};
            2'd1:    rx_next = {rx_sh[5:0], psram_io_in[1:0]};
            default: rx_next = {rx_sh[3:0], psram_io_in};
        endcase
    end

    // Phase that follows the current one once its last SCK has fallen.
    always_comb begin
        adv_state = END;
        case (state)
            CMD:     adv_state = c_cmd_only ? END : ADDR;
            ADDR:    adv_state = (c_wait_cyc != 4'd0) ? WAIT :
                                 (c_data_len != 15'd0) ? DATA : END;
            WAIT:    adv_state = (c_data_len != 15'd0) ? DATA : END;
            DATA:    adv_state = (byte_rem > 15'd1) ? DATA : END;
            default: adv_state = END;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            c_cmd_only   <= 1'b0;
            c_data_dir   <= 1'b0;
            c_single     <= 1'b0;
            c_cmd_width  <= 2'd0;
            c_addr_width <= 2'd0;
            c_data_width <= 2'd0;
            c_addr       <= 24'd0;
            c_wait_cyc   <= 4'd0;
            c_sck_div    <= 4'd0;
            c_data_len   <= 15'd0;
            div_cnt      <= 4'd0;
            byte_rem     <= 15'd0;
            sck_cnt      <= 5'd0;
            sh           <= 32'd0;
            rx_sh        <= 8'd0;
            rx_data      <= 8'd0;
            tx_pop       <= 1'b0;
            rx_push      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            psram_sck    <= 1'b0;
            psram_ce_n   <= 1'b1;
            psram_io_out <= 4'd0;
            psram_io_oe  <= 4'd0;
        end else begin
            tx_pop  <= 1'b0;
            rx_push <= 1'b0;
            done    <= 1'b0;
            if (sample_now) begin
                rx_sh <= rx_next;
                if (sck_cnt == 5'd0) begin
                    rx_data <= rx_next;
                    rx_push <= 1'b1;
                end
            end
            case (state)
                IDLE: begin
                    if (host.start) begin
                        c_cmd_width  <= host.cmd_width;
                        c_cmd_only   <= host.cmd_only;
                        c_addr       <= host.addr;
                        c_addr_width <= host.addr_width;
                        c_wait_cyc   <= host.wait_cyc;
                        c_data_width <= host.data_width;
                        c_data_dir   <= host.data_dir;
                        c_data_len   <= host.data_len;
                        c_sck_div    <= host.sck_div;
                        c_single     <= host.single_line_io_mode;
                        sh           <= {host.cmd, 24'd0};
                        psram_io_out <= lane_drive({host.cmd, 24'd0}, host.cmd_width);
                        psram_io_oe  <= lane_mask(host.cmd_width);
                        sck_cnt      <= last_sck(host.cmd_width, 1'b0);
                        div_cnt      <= host.sck_div;
                        psram_ce_n   <= 1'b0;
                        psram_sck    <= 1'b0;
                        busy         <= 1'b1;
                        state        <= CMD;
                    end
                end
                CMD, ADDR, WAIT, DATA: begin
                    if (!tick) begin
                        div_cnt <= div_cnt - 4'd1;
                    end else begin
                        div_cnt   <= c_sck_div;
                        psram_sck <= ~psram_sck;
                        if (psram_sck) begin
                            if (sck_cnt != 5'd0) begin
                                sck_cnt <= sck_cnt - 5'd1;
                                if (shifting) begin
                                    sh           <= sh_next;
                                    psram_io_out <= lane_drive(sh_next, cur_w);
                                end
                            end else begin
                                state <= adv_state;
                                case (adv_state)
                                    ADDR: begin
                                        sck_cnt      <= last_sck(c_addr_width, 1'b1);
                                        sh           <= {c_addr, 8'd0};
                                        psram_io_out <= lane_drive({c_addr, 8'd0}, c_addr_width);
                                        psram_io_oe  <= lane_mask(c_addr_width);
                                    end
                                    WAIT: begin
                                        sck_cnt      <= {1'b0, c_wait_cyc} - 5'd1;
                                        psram_io_out <= 4'd0;
                                        psram_io_oe  <= 4'd0;
                                    end
                                    DATA: begin
                                        sck_cnt  <= last_sck(c_data_width, 1'b0);
                                        byte_rem <= (state == DATA) ? byte_rem - 15'd1 : c_data_len;
                                        if (!c_data_dir) begin
                                            tx_pop       <= 1'b1;
                                            sh           <= {host.tx_data, 24'd0};
                                            psram_io_out <= lane_drive({host.tx_data, 24'd0}, c_data_width);
                                            psram_io_oe  <= lane_mask(c_data_width);
                                        end else begin
                                            psram_io_out <= 4'd0;
                                            psram_io_oe  <= 4'd0;
                                        end
                                    end
                                    default: begin
                                        psram_ce_n   <= 1'b1;
                                        psram_io_out <= 4'd0;
                                        psram_io_oe  <= 4'd0;
                                    end
                                endcase
                            end
                        end
                    end
                end
                END: begin
                    if (div_cnt != 4'd0) begin
                        div_cnt <= div_cnt - 4'd1;
                    end else begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
